// File: rtl/pulse_shot_if.sv
// pulse_shot_if: trigger inputs, shared pulse configuration and per-channel shot/busy outputs
interface pulse_shot_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W = 8
);
   logic [CHANNELS-1:0] start;
   logic [1:0] mode;
   logic retrigger;
   logic [CNT_W-1:0] pulse_len;
   logic [CNT_W-1:0] guard_len;
   logic [CHANNELS-1:0] shot;
   logic [CHANNELS-1:0] busy;
   modport master (output start, mode, retrigger, pulse_len, guard_len, input shot, busy);
   modport slave (input start, mode, retrigger, pulse_len, guard_len, output shot, busy);
endinterface

// File: rtl/pulse_shot_array.sv
// pulse_shot_array: per-channel edge-triggered one-shot with optional retrigger and guard interval
module pulse_shot_array #(
   parameter int CHANNELS = 4,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic reset,
   pulse_shot_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GUARD = 2'd2} state_t;
   logic [CNT_W-1:0] pulse_load;
   logic [CNT_W-1:0] guard_load;
   logic [CHANNELS-1:0] shot_v;
   logic [CHANNELS-1:0] busy_v;
   // a zero pulse length still yields a single-cycle pulse
   assign pulse_load = (bus.pulse_len == '0) ? '0 : bus.pulse_len - CNT_W'(1);
   assign guard_load = bus.guard_len - CNT_W'(1);
   assign bus.shot = shot_v;
   assign bus.busy = busy_v;
   genvar i;
   for (i = 0; i < CHANNELS; i++) begin : g_ch
      state_t state, state_n;
      logic [CNT_W-1:0] cnt, cnt_n;
      logic start_q, rise, fall, ev;
      assign rise = bus.start[i] & ~start_q;
      assign fall = ~bus.start[i] & start_q;
      assign ev = (bus.mode == 2'b01) ? fall : (bus.mode == 2'b10) ? (rise | fall) : rise;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            start_q <= 1'b0;
         end else begin
            state <= state_n;
            cnt <= cnt_n;
            start_q <= bus.start[i];
         end
      end
      always_comb begin
         state_n = state;
         cnt_n = cnt;
         case (state)
            IDLE: if (ev) begin
               state_n = PULSE;
               cnt_n = pulse_load;
            end
            PULSE: if (ev && bus.retrigger) cnt_n = pulse_load;
               else if (cnt != '0) cnt_n = cnt - CNT_W'(1);
               else if (bus.guard_len != '0) begin
                  state_n = GUARD;
                  cnt_n = guard_load;
               end else state_n = IDLE;
            GUARD: if (cnt != '0) cnt_n = cnt - CNT_W'(1);
               else state_n = IDLE;
            default: begin
               state_n = IDLE;
               cnt_n = '0;
            end
         endcase
      end
      assign shot_v[i] = (state == PULSE);
      assign busy_v[i] = (state == PULSE) || (state == GUARD);
   end
endmodule

// File: tb/tb_pulse_shot_array.sv
// tb_pulse_shot_array: directed windows with literal pulse counts plus a timestamp model checked every cycle
module tb_pulse_shot_array;
   localparam int CH = 4;
   localparam int CW = 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   pulse_shot_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();
   pulse_shot_array #(.CHANNELS(CH), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
   int vec = 0;
   int err = 0;
   // model: each channel keeps the edge index where its pulse ends and where its guard ends
   int n = 0;
   int pe [CH];
   int ge [CH];
   logic [CH-1:0] pq = '0;
   logic [CH-1:0] exp_shot = '0;
   logic [CH-1:0] exp_busy = '0;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         n <= 0;
         pq <= '0;
         exp_shot <= '0;
         exp_busy <= '0;
         for (int c = 0; c < CH; c++) begin
            pe[c] <= 0;
            ge[c] <= 0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            automatic int t = n + 1;
            automatic int l = (bus.pulse_len == 0) ? 1 : int'(bus.pulse_len);
            automatic int p = pe[c];
            automatic int g = ge[c];
            automatic logic r = bus.start[c] & ~pq[c];
            automatic logic f = ~bus.start[c] & pq[c];
            automatic logic ev = (bus.mode == 2'd1) ? f : (bus.mode == 2'd2) ? (r | f) : r;
            if (t <= p) begin
               if (ev && bus.retrigger) p = t + l;
               else if (t == p) g = t + int'(bus.guard_len);
            end else if (t > g && ev) p = t + l;
            pe[c] <= p;
            ge[c] <= g;
            exp_shot[c] <= (t < p);
            exp_busy[c] <= (t < p) || (t < g);
         end
         n <= n + 1;
         pq <= bus.start;
      end
   end
   int hi [CH];
   int rs [CH];
   int bz [CH];
   int fst [CH];
   int lst [CH];
   int idx;
   logic [CH-1:0] ps;
   task automatic chk(input string nm, input int act, input int expv);
      vec++;
      if (act != expv) begin
         err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, expv);
      end
   endtask
   task automatic clr();
      for (int c = 0; c < CH; c++) begin
         hi[c] = 0;
         rs[c] = 0;
         bz[c] = 0;
         fst[c] = -1;
         lst[c] = -1;
      end
      idx = 0;
      ps = bus.shot;
   endtask
   task automatic step(input logic [CH-1:0] s);
      @(posedge clk);
      #3 bus.start = s;
      @(negedge clk);
      vec++;
      if (bus.shot !== exp_shot || bus.busy !== exp_busy) begin
         err++;
         $display("FAIL model t=%0t: shot %b busy %b, want shot %b busy %b", $time, bus.shot, bus.busy, exp_shot, exp_busy);
      end
      for (int c = 0; c < CH; c++) begin
         if (bus.busy[c]) bz[c]++;
         if (bus.shot[c]) begin
            hi[c]++;
            if (!ps[c]) begin
               rs[c]++;
               if (fst[c] < 0) fst[c] = idx;
               lst[c] = idx;
            end
         end
      end
      ps = bus.shot;
      idx++;
   endtask
   initial begin
      bus.start = '0;
      bus.mode = 2'd0;
      bus.retrigger = 1'b0;
      bus.pulse_len = 8'd3;
      bus.guard_len = 8'd0;
      #1 reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(CH'($urandom_range(0, 15)));
         chk("reset_shot", int'(bus.shot), 0);
         chk("reset_busy", int'(bus.busy), 0);
      end
      bus.start = 4'b0001;
      @(posedge clk);
      #3 reset = 1'b1;
      clr();
      for (int k = 0; k < 8; k++) step(4'b0001);
      chk("release_hi0", hi[0], 3);
      chk("release_rise0", rs[0], 1);
      for (int k = 0; k < 3; k++) step(4'b0000);
      clr();
      for (int k = 0; k < 10; k++) step(4'b0010);
      for (int k = 0; k < 3; k++) step(4'b0000);
      chk("basic_hi1", hi[1], 3);
      chk("basic_rise1", rs[1], 1);
      chk("basic_busy1", bz[1], 3);
      bus.pulse_len = 8'd0;
      clr();
      for (int k = 0; k < 3; k++) step(4'b0010);
      for (int k = 0; k < 3; k++) step(4'b0000);
      chk("len0_hi1", hi[1], 1);
      bus.pulse_len = 8'd3;
      for (int m = 1; m < 4; m++) begin
         bus.mode = 2'(m);
         clr();
         for (int k = 0; k < 5; k++) step(4'b0100);
         for (int k = 0; k < 6; k++) step(4'b0000);
         chk($sformatf("mode%0d_hi2", m), hi[2], (m == 2) ? 6 : 3);
         chk($sformatf("mode%0d_first2", m), fst[2], (m == 1) ? 6 : 1);
         chk($sformatf("mode%0d_last2", m), lst[2], (m == 3) ? 1 : 6);
      end
      bus.mode = 2'd0;
      bus.pulse_len = 8'd4;
      for (int r = 1; r >= 0; r--) begin
         bus.retrigger = r[0];
         clr();
         step(4'b1000);
         step(4'b0000);
         step(4'b1000);
         for (int k = 0; k < 7; k++) step(4'b0000);
         chk($sformatf("retrig%0d_hi3", r), hi[3], r ? 6 : 4);
         chk($sformatf("retrig%0d_rise3", r), rs[3], 1);
      end
      bus.pulse_len = 8'd2;
      bus.guard_len = 8'd3;
      clr();
      for (int k = 0; k < 18; k++) step((k % 3 == 0) ? 4'b0001 : 4'b0000);
      chk("guard_hi0", hi[0], 6);
      chk("guard_rise0", rs[0], 3);
      chk("guard_first0", fst[0], 1);
      chk("guard_last0", lst[0], 13);
      chk("guard_busy0", bz[0], 15);
      bus.guard_len = 8'd0;
      bus.pulse_len = 8'd3;
      for (int k = 0; k < 5; k++) step(4'b0000);
      step(4'hF);
      step(4'hF);
      chk("all_shot", int'(bus.shot), 15);
      #2 reset = 1'b0;
      #1;
      chk("async_shot", int'(bus.shot), 0);
      chk("async_busy", int'(bus.busy), 0);
      step(4'h0);
      step(4'h0);
      @(posedge clk);
      #3 reset = 1'b1;
      for (int k = 0; k < 3; k++) step(4'h0);
      chk("post_reset_busy", int'(bus.busy), 0);
      for (int k = 0; k < 240; k++) begin
         if (k % 40 == 0) begin
            bus.mode = 2'($urandom_range(0, 3));
            bus.retrigger = 1'($urandom_range(0, 1));
            bus.pulse_len = 8'($urandom_range(0, 5));
            bus.guard_len = 8'($urandom_range(0, 4));
         end
         step(CH'($urandom_range(0, 15)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
